// File: rtl/sumador_input_conditioner.sv
// Input conditioner for the switch/button adder: synchronises and debounces
// the buttons into state-gated pulses, captures operands, holds curr_st.

module sumador_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic gate,
    output logic pulse
);
    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (s2 != stable) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Only rising acceptances pulse; a closed gate drops the press.
            pulse <= accept && s2 && !stable && gate;
        end
    end
endmodule

module sumador_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_enter1,
    input  logic       btn_enter2,
    input  logic       btn_clear,
    input  logic [2:0] sw_num1,
    input  logic [2:0] sw_num2,
    input  logic [1:0] next_st,
    output logic [1:0] curr_st,
    output logic [2:0] num1,
    output logic [2:0] num2,
    output logic       enter1,
    output logic       enter2,
    output logic       clear
);
    typedef enum logic [1:0] {
        STORE_NUM1 = 2'b00,
        STORE_NUM2 = 2'b01,
        ADD        = 2'b10,
        HALT       = 2'b11
    } st_e;

    logic [5:0] sw_s1;
    logic [5:0] sw_s2;
    logic       gate1;
    logic       gate2;
    logic       gate_clr;

    assign gate1    = (curr_st == STORE_NUM1);
    assign gate2    = (curr_st == STORE_NUM2);
    assign gate_clr = (curr_st == HALT);

    // curr_st is passed through untouched; legality is the sequencer's job.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            num1    <= '0;
            num2    <= '0;
            curr_st <= STORE_NUM1;
        end else begin
            sw_s1 <= {sw_num2, sw_num1};
            sw_s2 <= sw_s1;
            if (gate1) begin
                num1 <= sw_s2[2:0];
            end
            if (gate2) begin
                num2 <= sw_s2[5:3];
            end
            curr_st <= next_st;
        end
    end

    sumador_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_enter1 (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_enter1),
        .gate (gate1),
        .pulse(enter1)
    );

    sumador_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_enter2 (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_enter2),
        .gate (gate2),
        .pulse(enter2)
    );

    sumador_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_clear (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_clear),
        .gate (gate_clr),
        .pulse(clear)
    );
endmodule

// File: tb/tb_sumador_input_conditioner.sv
// Bench for sumador_input_conditioner: directed button/switch/state vectors
// with a sample-window reference model compared every cycle.

module tb_sumador_input_conditioner;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_enter1 = 1'b0;
    logic       btn_enter2 = 1'b0;
    logic       btn_clear = 1'b0;
    logic [2:0] sw_num1 = 3'd0;
    logic [2:0] sw_num2 = 3'd0;
    logic [1:0] next_st = 2'd0;
    logic [1:0] curr_st;
    logic [2:0] num1;
    logic [2:0] num2;
    logic       enter1;
    logic       enter2;
    logic       clear;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_pulse [3];
    int last_pulse [3];

    // Reference model state
    logic [2:0]   m_b1, m_b2;
    logic [5:0]   m_sw1, m_sw2;
    logic [2:0]   m_stable;
    logic [D-1:0] m_hist [3];
    logic [2:0]   m_pulse;
    logic [2:0]   m_num1, m_num2;
    logic [1:0]   m_curr;

    sumador_input_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_enter1(btn_enter1),
        .btn_enter2(btn_enter2),
        .btn_clear (btn_clear),
        .sw_num1   (sw_num1),
        .sw_num2   (sw_num2),
        .next_st   (next_st),
        .curr_st   (curr_st),
        .num1      (num1),
        .num2      (num2),
        .enter1    (enter1),
        .enter2    (enter2),
        .clear     (clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a press is accepted once the last D synchronised samples
    // all disagree with the accepted level.
    initial begin
        logic [2:0] s2v;
        logic       acc;
        logic       gate;
        n_pulse = '{0, 0, 0};
        last_pulse = '{-1, -1, -1};
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_b1 = '0; m_b2 = '0; m_sw1 = '0; m_sw2 = '0;
                m_stable = '0; m_pulse = '0;
                m_num1 = '0; m_num2 = '0; m_curr = '0;
                for (int b = 0; b < 3; b++) m_hist[b] = '0;
            end else begin
                s2v = m_b2;
                for (int b = 0; b < 3; b++) begin
                    m_hist[b] = {m_hist[b][D-2:0], s2v[b]};
                    acc = (m_hist[b] == (m_stable[b] ? {D{1'b0}} : {D{1'b1}}));
                    gate = (b == 0) ? (m_curr == 2'd0) :
                           (b == 1) ? (m_curr == 2'd1) : (m_curr == 2'd3);
                    m_pulse[b] = acc && s2v[b] && gate;
                    if (acc) m_stable[b] = s2v[b];
                end
                if (m_curr == 2'd0) m_num1 = m_sw2[2:0];
                if (m_curr == 2'd1) m_num2 = m_sw2[5:3];
                m_curr = next_st;
                m_b2 = m_b1;
                m_b1 = {btn_clear, btn_enter2, btn_enter1};
                m_sw2 = m_sw1;
                m_sw1 = {sw_num2, sw_num1};
            end
            #1;
            chk("curr_st", 32'(curr_st), 32'(m_curr));
            chk("num1", 32'(num1), 32'(m_num1));
            chk("num2", 32'(num2), 32'(m_num2));
            chk("enter1", 32'(enter1), 32'(m_pulse[0]));
            chk("enter2", 32'(enter2), 32'(m_pulse[1]));
            chk("clear", 32'(clear), 32'(m_pulse[2]));
            if (enter1 === 1'b1) begin n_pulse[0]++; last_pulse[0] = cyc; end
            if (enter2 === 1'b1) begin n_pulse[1]++; last_pulse[1] = cyc; end
            if (clear === 1'b1) begin n_pulse[2]++; last_pulse[2] = cyc; end
        end
    end

    initial begin
        int p0, p1, p2, ref_cyc;
        logic bp [5];
        logic [1:0] seq [5];
        bp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        step(3);
        chk("rst_curr_st", 32'(curr_st), 0);
        chk("rst_num1", 32'(num1), 0);
        chk("rst_pulses", 32'({enter1, enter2, clear}), 0);
        reset = 1'b0;
        step(2);

        // Clean press
        p0 = n_pulse[0];
        btn_enter1 = 1'b1;
        ref_cyc = cyc + 1;
        step(20);
        btn_enter1 = 1'b0;
        step(12);
        chk("clean_count", n_pulse[0] - p0, 1);
        chk("clean_edge", last_pulse[0], ref_cyc + 5);

        // Bounce
        p0 = n_pulse[0];
        for (int i = 0; i < 5; i++) begin
            btn_enter1 = bp[i];
            step(1);
        end
        btn_enter1 = 1'b1;
        ref_cyc = cyc + 1;
        step(15);
        chk("bounce_count", n_pulse[0] - p0, 1);
        chk("bounce_edge", last_pulse[0], ref_cyc + 5);
        btn_enter1 = 1'b0;
        step(12);

        // Simultaneous enter1/enter2 in STORE_NUM1
        p0 = n_pulse[0];
        p1 = n_pulse[1];
        btn_enter1 = 1'b1;
        btn_enter2 = 1'b1;
        step(12);
        chk("simul_e1", n_pulse[0] - p0, 1);
        chk("simul_e2", n_pulse[1] - p1, 0);
        btn_enter1 = 1'b0;
        btn_enter2 = 1'b0;
        step(12);

        // Operand capture
        sw_num1 = 3'd5;
        step(2);
        chk("num1_early", 32'(num1), 0);
        step(1);
        chk("num1_load", 32'(num1), 5);
        next_st = 2'd1;
        step(2);
        sw_num1 = 3'd2;
        sw_num2 = 3'd3;
        step(4);
        chk("num1_frozen", 32'(num1), 5);
        chk("num2_load", 32'(num2), 3);
        p1 = n_pulse[1];
        btn_enter2 = 1'b1;
        step(12);
        chk("e2_in_01", n_pulse[1] - p1, 1);
        btn_enter2 = 1'b0;
        step(12);

        // Gating in ADD, then HALT
        next_st = 2'd2;
        step(2);
        p0 = n_pulse[0]; p1 = n_pulse[1]; p2 = n_pulse[2];
        btn_enter1 = 1'b1; btn_enter2 = 1'b1; btn_clear = 1'b1;
        step(12);
        chk("add_no_pulse", (n_pulse[0] - p0) + (n_pulse[1] - p1)
                            + (n_pulse[2] - p2), 0);
        btn_enter1 = 1'b0; btn_enter2 = 1'b0; btn_clear = 1'b0;
        step(12);
        next_st = 2'd3;
        step(2);
        p0 = n_pulse[0]; p2 = n_pulse[2];
        btn_clear = 1'b1;
        btn_enter1 = 1'b1;
        step(12);
        chk("halt_clear", n_pulse[2] - p2, 1);
        chk("halt_no_e1", n_pulse[0] - p0, 0);
        btn_clear = 1'b0;
        btn_enter1 = 1'b0;
        step(12);

        // Reset mid-debounce with button held
        next_st = 2'd0;
        step(2);
        btn_enter1 = 1'b1;
        step(4);
        reset = 1'b1;
        step(2);
        chk("mid_rst_curr_st", 32'(curr_st), 0);
        chk("mid_rst_num1", 32'(num1), 0);
        chk("mid_rst_num2", 32'(num2), 0);
        chk("mid_rst_pulses", 32'({enter1, enter2, clear}), 0);
        p0 = n_pulse[0];
        reset = 1'b0;
        ref_cyc = cyc + 1;
        step(12);
        chk("post_rst_count", n_pulse[0] - p0, 1);
        chk("post_rst_edge", last_pulse[0], ref_cyc + 5);
        btn_enter1 = 1'b0;
        step(12);

        // State follow
        for (int i = 0; i < 5; i++) begin
            next_st = seq[i];
            step(1);
            chk("state_follow", 32'(curr_st), 32'(seq[i]));
        end
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sumador_input_conditioner.md
# sumador_input_conditioner

Front-end stage for the switch/button adder datapath. It synchronises and debounces the three raw push-buttons into single-cycle, state-gated pulses (`enter1`, `enter2`, `clear`). It samples the two 3-bit operand switch banks into stable operand registers. It also owns the 2-bit sequencer state register, closing the loop `next_st -> curr_st` for the downstream adder sequencer, which consumes all outputs of this block.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised button level must differ from its debounced level before it is accepted (≥2). Counter width is `ceil(log2(DEBOUNCE_CYCLES))`.

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `btn_enter1`  in  1  raw, asynchronous, bouncy button (confirm operand 1)
- `btn_enter2`  in  1  raw button (confirm operand 2)
- `btn_clear`  in  1  raw button (restart after result)
- `sw_num1`  in  3  raw operand-1 switches
- `sw_num2`  in  3  raw operand-2 switches
- `next_st`  in  2  next state from the adder sequencer
- `curr_st`  out  2  registered sequencer state; encoding 00 STORE_NUM1, 01 STORE_NUM2, 10 ADD, 11 HALT
- `num1`  out  3  operand-1 register
- `num2`  out  3  operand-2 register
- `enter1`  out  1  one-cycle pulse, only in STORE_NUM1
- `enter2`  out  1  one-cycle pulse, only in STORE_NUM2
- `clear`  out  1  one-cycle pulse, only in HALT

## Operation
- **Synchronisers.** Each button and each switch bit passes through a 2-flop synchroniser (`s1 -> s2`).
- **Per-button debounce.** Each button has a `stable` bit and a counter `cnt`. On every edge:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Pulse generation.** A pulse register is loaded as `(accept event) && s2 && !stable && gate`. It is high for exactly one cycle per accepted rising transition.
  - Accepted falling transitions update `stable` only and never pulse.
- **Gating.** Gates use the registered `curr_st` at the same edge:
  - `enter1`: `curr_st==00`
  - `enter2`: `curr_st==01`
  - `clear`: `curr_st==11`
  - A gated-out press is dropped, not queued. `stable` still updates, so a held button never pulses later.
- **Operand registers.**
  - `num1 <= s2(sw_num1)` on every edge while `curr_st==00`; frozen otherwise.
  - `num2 <= s2(sw_num2)` while `curr_st==01`; frozen otherwise.
- **State register.** `curr_st <= next_st` on every non-reset edge. The block never alters the value or checks its legality.
- **Reset.**
  - `reset` high at an edge zeroes all synchronisers, `stable` bits, counters, pulses, `num1`, `num2` and `curr_st` (00). This applies mid-operation as well; any partial debounce is discarded.
  - `reset` must be held ≥2 cycles so the downstream `next_st` settles to 00.
- A button held through reset is seen as a new press after reset deasserts: debounce runs and pulses if its gate is open.

## Timing
- **Button latency.** Raw level first sampled at edge E0 -> `s2` valid after E1 -> accept and pulse registered at E(DEBOUNCE_CYCLES+1). The pulse is high for the cycle after that edge only.
- **Bounce filtering.**
  - A bounce or glitch that returns within fewer than DEBOUNCE_CYCLES cycles of differing `s2` produces no pulse and no `stable` change.
  - Any return of `s2` to `stable` restarts the count from 0.
- **Switch latency.** Raw switch -> `num` visible after 3 edges (2 sync + load), provided the state is open throughout.
- **State.** `curr_st` lags `next_st` by exactly one edge.
- **Simultaneous events.** Presses on several buttons are processed independently; only the gated pulse appears. For example, `enter1` and `enter2` accepted together in 00 -> only `enter1`.
- Maximum pulse rate per button: one per 2·DEBOUNCE_CYCLES cycles (press plus release debounce).

## Test plan
- **Clean press.** DEBOUNCE_CYCLES=4, `curr_st`=00; `btn_enter1` 0->1 before E0, held 20 cycles -> `enter1` high only in the cycle after E5; no further pulse while held or on release.
- **Bounce.** DEBOUNCE_CYCLES=4; `btn_enter1` pattern 1,0,1,1,0 (1 cycle each) then steady 1 -> no pulse during bounce; single pulse 6 edges after the last 0->1.
- **Gating.** `next_st` held 10 (ADD); press all three buttons -> no pulses. Then `next_st`=11 and press `btn_clear` -> `clear` pulse; simultaneous `btn_enter1` press produces nothing.
- **Operand capture.** `sw_num1`=5 in state 00 -> `num1`=5 after 3 edges. `next_st`=01, then `sw_num1`=2 -> `num1` stays 5. `sw_num2`=3 -> `num2`=3.
- **Reset mid-debounce.** Counter at 2 of 4, assert `reset` 2 cycles -> all outputs 0, `curr_st`=00. With the button still held, a pulse arrives DEBOUNCE_CYCLES+2 edges after `reset` deasserts.
- **State follow.** Drive `next_st` 00,01,10,11,00 on consecutive cycles -> `curr_st` repeats the sequence one edge later.
